// File: rtl/insfetch.sv
// Multithreaded instruction fetch stage.
// Keeps one PC per hardware thread plus an active mask, picks one active
// thread per cycle round-robin, reads a combinational instruction memory
// and registers the result into the IF/ID pipeline register. Thread
// start/end and jump redirects from later stages update the per-thread
// state, and wrong-path instructions sitting in IF/ID are squashed.
// Thread IDs are 3 bits wide, so NUM_TRD is expected to stay at 8.
module insfetch #(
  parameter int unsigned NUM_TRD  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        jmp_valid,
  input  logic [2:0]  jmp_trd,
  input  logic [31:0] jmp_pc,
  input  logic        trd_start,
  input  logic [2:0]  trd_start_id,
  input  logic [31:0] trd_start_pc,
  input  logic        trd_end,
  input  logic [2:0]  trd_end_id,
  output logic [31:0] ins_dec,
  output logic [31:0] pc_dec,
  output logic [2:0]  trd_dec,
  output logic        valid_dec,
  output logic        idle,
  output logic        start_err
);

  localparam int unsigned TW = 3;

  logic [31:0]        pc [NUM_TRD];
  logic [NUM_TRD-1:0] active;
  logic [TW-1:0]      rr_ptr;
  logic [TW-1:0]      sel;
  logic [TW-1:0]      cand;
  logic               found;
  logic               fetch_ok;
  logic               squash;
  logic               kill_sel;
  logic               fetch_go;

  // Round-robin pick: first active thread after rr_ptr, rr_ptr itself last.
  always_comb begin
    sel   = rr_ptr;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      cand = rr_ptr + TW'(i);
      if (!found && active[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Fetch qualification.
  // A redirect or end that hits the selected thread makes this cycle's
  // fetch wrong-path, so it is dropped and that PC is not advanced. Any
  // squash of IF/ID also holds fetch back so the bubble it writes never
  // overwrites a live instruction from another thread.
  always_comb begin
    fetch_ok  = |active;
    idle      = !fetch_ok;
    imem_addr = pc[sel];
    squash    = valid_dec &&
                ((jmp_valid && (jmp_trd == trd_dec)) ||
                 (trd_end && (trd_end_id == trd_dec)));
    kill_sel  = (jmp_valid && (jmp_trd == sel)) ||
                (trd_end && (trd_end_id == sel));
    fetch_go  = !stall && fetch_ok && !squash && !kill_sel;
  end

  // Per-thread active flag and PC: end > start > jump > fetch increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NUM_TRD; t++) begin
        pc[t] <= (t == 0) ? RESET_PC : '0;
      end
      active <= NUM_TRD'(1);
    end else begin
      for (int unsigned t = 0; t < NUM_TRD; t++) begin
        if (trd_end && (trd_end_id == TW'(t))) begin
          active[t] <= 1'b0;
        end else if (trd_start && (trd_start_id == TW'(t)) && !active[t]) begin
          active[t] <= 1'b1;
          pc[t]     <= trd_start_pc;
        end else if (jmp_valid && (jmp_trd == TW'(t)) && active[t]) begin
          pc[t] <= jmp_pc;
        end else if (fetch_go && (sel == TW'(t))) begin
          pc[t] <= pc[t] + 32'd4;
        end
      end
    end
  end

  // Round-robin pointer advances only on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 3'd7;
    end else if (fetch_go) begin
      rr_ptr <= sel;
    end
  end

  // One-cycle error pulse for a start aimed at an already-running thread.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_err <= 1'b0;
    end else begin
      start_err <= trd_start && active[trd_start_id];
    end
  end

  // IF/ID register: load on fetch, bubble on squash or no fetch, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_dec   <= '0;
      pc_dec    <= '0;
      trd_dec   <= '0;
      valid_dec <= 1'b0;
    end else if (fetch_go) begin
      ins_dec   <= imem_rdata;
      pc_dec    <= pc[sel];
      trd_dec   <= sel;
      valid_dec <= 1'b1;
    end else if (squash || !stall) begin
      ins_dec   <= '0;
      pc_dec    <= '0;
      trd_dec   <= '0;
      valid_dec <= 1'b0;
    end
  end

endmodule

// File: doc/insfetch.md
Name: insfetch

Overview:
- Multithreaded instruction fetch stage. It sits directly upstream of the decode/register stage and produces ins_dec, pc_dec and trd_dec.
- Holds one PC per hardware thread and tracks which threads are active. Each cycle it picks one active thread round-robin and fetches from a combinational-read instruction memory.
- Registers the fetched instruction into the IF/ID pipeline register.
- Applies thread start/end and jump redirects coming back from later stages, and squashes wrong-path instructions held in IF/ID.

Parameters:
- NUM_TRD, 8, number of hardware threads; thread ID width is 3 bits, fixed.
- RESET_PC, 32'h0000_0000, start PC of thread 0 after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- stall  in  1  pipeline stall; freezes fetch and the IF/ID register.
- imem_addr  out  32  instruction memory address (combinational).
- imem_rdata  in  32  instruction word; valid in the same cycle as imem_addr.
- jmp_valid  in  1  redirect request from execute.
- jmp_trd  in  3  thread being redirected.
- jmp_pc  in  32  redirect target.
- trd_start  in  1  start a thread; issued by writeback on thread init.
- trd_start_id  in  3  thread to start.
- trd_start_pc  in  32  start PC of that thread.
- trd_end  in  1  terminate a thread.
- trd_end_id  in  3  thread to terminate.
- ins_dec  out  32  IF/ID instruction; 32'h0 is the NOP/bubble encoding.
- pc_dec  out  32  IF/ID PC.
- trd_dec  out  3  IF/ID thread ID.
- valid_dec  out  1  IF/ID holds a real instruction.
- idle  out  1  no thread is active (combinational).
- start_err  out  1  one-cycle pulse: trd_start targeted an already-active thread.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Values held during reset:
  - pc[0] = RESET_PC, all other pc = 0.
  - active = 8'b0000_0001.
  - rr_ptr = 7.
  - ins_dec = 0, pc_dec = 0, trd_dec = 0, valid_dec = 0, start_err = 0.
- Thread selection (combinational):
  - sel = first active thread in the order rr_ptr+1, rr_ptr+2, … rr_ptr+8, modulo 8 (rr_ptr itself is checked last).
  - fetch_ok = |active.
  - imem_addr = pc[sel].
  - idle = !fetch_ok.
- Normal fetch, when !stall and fetch_ok, one cycle latency:
  - ins_dec <= imem_rdata, pc_dec <= pc[sel], trd_dec <= sel, valid_dec <= 1.
  - pc[sel] <= pc[sel] + 4, modulo 2^32 (wraps from FFFF_FFFC to 0).
  - rr_ptr <= sel.
  - With one active thread, that thread is fetched every cycle.
- No active thread, when !stall: IF/ID loads a bubble (ins 0, pc 0, trd 0, valid 0). pc and rr_ptr are unchanged.
- Stall:
  - pc, rr_ptr and the IF/ID register hold.
  - Exceptions that still apply during stall: thread control, redirects and squash (below).
- Squash: applies regardless of stall.
  - Trigger: a jmp_valid or trd_end in cycle N whose thread equals the current trd_dec while valid_dec = 1.
  - Effect: IF/ID loads a bubble at the edge ending cycle N.
  - If sel equals that thread in the same cycle, the fetched instruction is discarded (bubble loaded) and pc[sel] does not increment.
- Per-thread update priority at a clock edge, highest first:
  1. trd_end: active[t] <= 0.
  2. trd_start on an inactive thread: active[t] <= 1, pc[t] <= trd_start_pc.
  3. jmp_valid on an active thread: pc[t] <= jmp_pc.
  4. Fetch increment.
- Edge cases for thread control:
  - trd_start on an already-active thread is ignored, and start_err pulses high for one cycle.
  - jmp_valid on an inactive thread is ignored.
  - trd_start and trd_end on the same thread in the same cycle: trd_end wins and the thread stays inactive.
- Timing of selection changes:
  - Thread control and redirects are visible to selection in the next cycle, never the same cycle.
  - A thread started in cycle N can be fetched at the earliest in cycle N+1.
- Reset mid-operation: everything immediately returns to its reset values, including IF/ID and the active mask.

Test Plan:
- Reset release, RESET_PC = 0x100, imem returns 0xA0000000 + addr. Required: trd_dec = 0 each cycle; pc_dec = 0x100, 0x104, 0x108; ins_dec tracks imem; valid_dec = 1 from the first edge after reset.
- trd_start id = 3, pc = 0x400, while thread 0 runs. Required: from the next cycle selection alternates 3, 0, 3, 0; pc_dec for thread 3 is 0x400, 0x404; thread 0 continues without gaps in its PC sequence.
- jmp_valid trd = 0, pc = 0x800, while trd_dec = 0 and valid_dec = 1, single active thread. Required: IF/ID becomes a bubble (valid 0, ins 0); next fetched pc_dec = 0x800, then 0x804.
- stall held 3 cycles during 2-thread fetch. Required: ins/pc/trd_dec hold their values. A jmp on the thread not in IF/ID during the stall redirects it, and its first fetch after stall release uses jmp_pc.
- trd_end on the only active thread. Required: idle = 1 next cycle, bubbles are emitted, pc is frozen. Then trd_start id = 0 → start_err = 0 and fetch resumes at the given PC.
- Corner cases:
  - trd_start on an active thread → start_err pulses high for one cycle.
  - Same-cycle trd_start and trd_end on thread 5 → thread 5 stays inactive.
  - Thread PC at 0xFFFFFFFC → next pc_dec for that thread is 0x00000000.
